// File: rtl/evm_booth_arbiter.sv
// Central tally controller: election phase FSM, round-robin booth arbitration
// (one vote per cycle), four saturating option counters and a registered read port.
module evm_booth_arbiter #(
   parameter int NUM_BOOTHS = 4,
   parameter int COUNT_W    = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    open_cmd,
   input  logic                    close_cmd,
   input  logic [NUM_BOOTHS-1:0]   req,
   input  logic [2*NUM_BOOTHS-1:0] vote_opt,
   output logic [NUM_BOOTHS-1:0]   grant,
   output logic                    voting_open,
   output logic                    results_valid,
   output logic [COUNT_W+1:0]      total_votes,
   output logic                    overflow,
   input  logic [1:0]              rd_sel,
   output logic [COUNT_W-1:0]      rd_count
);

   localparam int IDX_W = (NUM_BOOTHS > 1) ? $clog2(NUM_BOOTHS) : 1;
   localparam logic [COUNT_W-1:0] CNT_MAX   = {COUNT_W{1'b1}};
   localparam logic [COUNT_W+1:0] TOTAL_MAX = {(COUNT_W+2){1'b1}};

   typedef enum logic [1:0] {
      ST_CLOSED  = 2'd0,
      ST_OPEN    = 2'd1,
      ST_TALLIED = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       ptr_q, ptr_d;
   logic [NUM_BOOTHS-1:0]  grant_q, grant_d;
   logic [COUNT_W-1:0]     cnt_q [4];
   logic [COUNT_W-1:0]     cnt_d [4];
   logic [COUNT_W+1:0]     total_q, total_d;
   logic                   overflow_q, overflow_d;
   logic [COUNT_W-1:0]     rd_count_q, rd_count_d;

   logic                   arb_en_s;
   logic [NUM_BOOTHS-1:0]  elig_s;
   logic                   win_found_s;
   logic [IDX_W-1:0]       win_idx_s;
   logic [1:0]             win_opt_s;
   int unsigned            cand_s;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_CLOSED;
         ptr_q      <= '0;
         grant_q    <= '0;
         total_q    <= '0;
         overflow_q <= 1'b0;
         rd_count_q <= '0;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         grant_q    <= grant_d;
         total_q    <= total_d;
         overflow_q <= overflow_d;
         rd_count_q <= rd_count_d;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_CLOSED:  if (open_cmd)  state_d = ST_OPEN;    else state_d = ST_CLOSED;
         ST_OPEN:    if (close_cmd) state_d = ST_TALLIED; else state_d = ST_OPEN;
         ST_TALLIED: state_d = ST_TALLIED;
         default:    state_d = ST_CLOSED;
      endcase
   end

   // A booth whose grant is showing is masked so its falling req is not counted twice.
   always_comb begin
      arb_en_s    = (state_q == ST_OPEN) && !close_cmd;
      elig_s      = req & ~grant_q;
      win_found_s = 1'b0;
      win_idx_s   = '0;
      cand_s      = 0;
      for (int k = 0; k < NUM_BOOTHS; k++) begin
         cand_s = (int'(ptr_q) + k) % NUM_BOOTHS;
         if (!win_found_s && elig_s[cand_s]) begin
            win_found_s = 1'b1;
            win_idx_s   = IDX_W'(cand_s);
         end else begin
            win_found_s = win_found_s;
         end
      end
      win_opt_s = vote_opt[{win_idx_s, 1'b0} +: 2];
   end

   always_comb begin
      grant_d    = '0;
      ptr_d      = ptr_q;
      total_d    = total_q;
      overflow_d = overflow_q;
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = cnt_q[i];
      end
      if (arb_en_s && win_found_s) begin
         grant_d[win_idx_s] = 1'b1;
         if (win_idx_s == IDX_W'(NUM_BOOTHS - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = win_idx_s + IDX_W'(1);
         end
         if (cnt_q[win_opt_s] == CNT_MAX) begin
            overflow_d = 1'b1;
         end else begin
            cnt_d[win_opt_s] = cnt_q[win_opt_s] + COUNT_W'(1);
         end
         if (total_q != TOTAL_MAX) begin
            total_d = total_q + (COUNT_W+2)'(1);
         end else begin
            total_d = total_q;
         end
      end else begin
         grant_d = '0;
      end
   end

   always_comb begin
      if (state_q == ST_TALLIED) begin
         rd_count_d = cnt_q[rd_sel];
      end else begin
         rd_count_d = '0;
      end
   end

   always_comb begin
      voting_open   = (state_q == ST_OPEN);
      results_valid = (state_q == ST_TALLIED);
      grant         = grant_q;
      total_votes   = total_q;
      overflow      = overflow_q;
      rd_count      = rd_count_q;
   end

endmodule

// File: tb/tb_evm_booth_arbiter.sv
// Directed bench for evm_booth_arbiter: a default instance for phases, arbitration
// and reads, and a COUNT_W=2 instance sharing the same stimulus for saturation.
module tb_evm_booth_arbiter;

   logic       clk = 1'b0;
   logic       reset, open_cmd, close_cmd;
   logic [3:0] req;
   logic [7:0] vote_opt;
   logic [1:0] rd_sel;

   logic [3:0] grant, grant_s;
   logic       voting_open, results_valid, overflow;
   logic       voting_open_s, results_valid_s, overflow_s;
   logic [9:0] total_votes;
   logic [3:0] total_votes_s;
   logic [7:0] rd_count;
   logic [1:0] rd_count_s;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   evm_booth_arbiter #(.NUM_BOOTHS(4), .COUNT_W(8)) dut (
      .clk(clk), .reset(reset), .open_cmd(open_cmd), .close_cmd(close_cmd),
      .req(req), .vote_opt(vote_opt), .grant(grant), .voting_open(voting_open),
      .results_valid(results_valid), .total_votes(total_votes), .overflow(overflow),
      .rd_sel(rd_sel), .rd_count(rd_count)
   );

   evm_booth_arbiter #(.NUM_BOOTHS(4), .COUNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .open_cmd(open_cmd), .close_cmd(close_cmd),
      .req(req), .vote_opt(vote_opt), .grant(grant_s), .voting_open(voting_open_s),
      .results_valid(results_valid_s), .total_votes(total_votes_s), .overflow(overflow_s),
      .rd_sel(rd_sel), .rd_count(rd_count_s)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Sample point is 1 time unit after the rising edge; inputs change there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic do_open();
      open_cmd = 1'b1;
      tick();
      open_cmd = 1'b0;
   endtask

   task automatic do_close();
      close_cmd = 1'b1;
      tick();
      close_cmd = 1'b0;
   endtask

   task automatic read_opt(input logic [1:0] sel, input logic [31:0] exp, input string tag);
      rd_sel = sel;
      tick();
      check_val(tag, 32'(rd_count), exp);
   endtask

   initial begin
      reset = 1'b0; open_cmd = 1'b0; close_cmd = 1'b0;
      req = 4'b0000; vote_opt = 8'h00; rd_sel = 2'd0;

      // 1. Reset and phase sequencing; requests in CLOSED are ignored
      do_reset();
      check_val("rst_grant", 32'(grant), 32'h0);
      check_val("rst_open", 32'(voting_open), 32'h0);
      check_val("rst_valid", 32'(results_valid), 32'h0);
      check_val("rst_total", 32'(total_votes), 32'h0);
      check_val("rst_ovf", 32'(overflow), 32'h0);
      check_val("rst_rd", 32'(rd_count), 32'h0);
      req = 4'b1111;
      tick();
      check_val("closed_req_grant", 32'(grant), 32'h0);
      tick();
      check_val("closed_req_grant2", 32'(grant), 32'h0);
      req = 4'b0000;
      do_open();
      check_val("open_vo", 32'(voting_open), 32'h1);
      check_val("open_rv", 32'(results_valid), 32'h0);
      check_val("open_total", 32'(total_votes), 32'h0);

      // 2. Single vote: booth 1, option 2
      vote_opt = 8'b00_00_10_00;
      req = 4'b0010;
      tick();
      check_val("single_grant", 32'(grant), 32'h2);
      check_val("single_total", 32'(total_votes), 32'h1);
      req = 4'b0000;
      tick();
      check_val("single_grant_off", 32'(grant), 32'h0);
      check_val("rd_in_open", 32'(rd_count), 32'h0);
      do_close();
      check_val("close_vo", 32'(voting_open), 32'h0);
      check_val("close_rv", 32'(results_valid), 32'h1);
      read_opt(2'd2, 32'd1, "single_rd_opt2");
      read_opt(2'd0, 32'd0, "single_rd_opt0");
      open_cmd = 1'b1;
      tick();
      open_cmd = 1'b0;
      check_val("tallied_open_ign", 32'(voting_open), 32'h0);
      check_val("tallied_stays", 32'(results_valid), 32'h1);

      // 3. Contention: all booths vote option 3
      do_reset();
      do_open();
      vote_opt = 8'hFF;
      req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         tick();
         check_val($sformatf("rr_grant%0d", k), 32'(grant), 32'(4'b0001 << k));
         req = req & ~grant;
      end
      tick();
      check_val("rr_idle", 32'(grant), 32'h0);
      check_val("rr_total", 32'(total_votes), 32'd4);
      do_close();
      read_opt(2'd3, 32'd4, "rr_rd_opt3");
      read_opt(2'd1, 32'd0, "rr_rd_opt1");

      // 4. Fairness after booth 2, then 5. close with a pending request
      do_reset();
      do_open();
      vote_opt = 8'b00_01_00_00;
      req = 4'b0100;
      tick();
      check_val("fair_first", 32'(grant), 32'h4);
      req = 4'b0101;
      tick();
      check_val("fair_booth0", 32'(grant), 32'h1);
      req = 4'b0100;
      tick();
      check_val("fair_booth2", 32'(grant), 32'h4);
      req = 4'b1000;
      close_cmd = 1'b1;
      tick();
      close_cmd = 1'b0;
      check_val("close_req_grant", 32'(grant), 32'h0);
      check_val("close_req_rv", 32'(results_valid), 32'h1);
      tick();
      check_val("tallied_req_grant", 32'(grant), 32'h0);
      check_val("tallied_total", 32'(total_votes), 32'd3);
      req = 4'b0000;
      read_opt(2'd1, 32'd2, "fair_rd_opt1");
      read_opt(2'd0, 32'd1, "fair_rd_opt0");

      // 6. Saturation on the 2-bit counter instance: five votes for option 1
      do_reset();
      do_open();
      vote_opt = 8'b00_00_00_01;
      for (int v = 0; v < 5; v++) begin
         req = 4'b0001;
         tick();
         check_val($sformatf("sat_grant%0d", v), 32'(grant_s), 32'h1);
         req = 4'b0000;
         tick();
      end
      check_val("sat_ovf", 32'(overflow_s), 32'h1);
      check_val("sat_total", 32'(total_votes_s), 32'd5);
      check_val("nosat_ovf", 32'(overflow), 32'h0);
      do_close();
      rd_sel = 2'd1;
      tick();
      check_val("sat_rd", 32'(rd_count_s), 32'd3);
      do_reset();
      check_val("sat_rst_ovf", 32'(overflow_s), 32'h0);
      check_val("sat_rst_total", 32'(total_votes_s), 32'h0);
      do_open();
      do_close();
      rd_sel = 2'd1;
      tick();
      check_val("sat_rst_rd", 32'(rd_count_s), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/evm_booth_arbiter.md
# evm_booth_arbiter

Central tally controller for a multi-booth voting system. Up to NUM_BOOTHS verified booth front-ends share one set of per-option vote counters. The block sequences the election phases (closed, open, tallied) and arbitrates booth vote requests round-robin, granting one vote per cycle. It exposes the final per-option results through a registered read port.

## Interface

**Parameters**
- NUM_BOOTHS, default 4: number of requesting booths; legal range 2..8.
- COUNT_W, default 8: width of each per-option counter.

**Ports** (name, direction, width, meaning)
- clk, input, 1: single clock; all state changes on its rising edge.
- reset, input, 1: synchronous, active-high; clears all state.
- open_cmd, input, 1: one-cycle pulse that opens voting. Honoured only in CLOSED.
- close_cmd, input, 1: one-cycle pulse that closes voting. Honoured only in OPEN.
- req, input, NUM_BOOTHS: per-booth vote request. Held high until that booth's grant is seen.
- vote_opt, input, 2*NUM_BOOTHS: 2-bit option per booth (booth i at bits 2i+1:2i). Must be stable while that booth's req is high.
- grant, output, NUM_BOOTHS: one-hot, single-cycle acknowledgement.
- voting_open, output, 1: high in OPEN.
- results_valid, output, 1: high in TALLIED.
- total_votes, output, COUNT_W+2: number of grants issued.
- overflow, output, 1: sticky; set when any option counter saturates.
- rd_sel, input, 2: option index to read.
- rd_count, output, COUNT_W: registered count for the rd_sel option.

## Operation

**States** (reset state is CLOSED)
- CLOSED → OPEN on open_cmd.
- OPEN → TALLIED on close_cmd.
- TALLIED is terminal; only reset leaves it.
- open_cmd outside CLOSED is ignored. close_cmd outside OPEN is ignored.

**Arbitration**
- Active only in OPEN.
- The eligible set is req minus any booth whose grant is currently high. This prevents a double count while the booth is dropping req.
- Round-robin pointer: the highest-priority booth is the one after the last granted booth, with wrap-around. After reset, booth 0 has highest priority.
- At most one grant per cycle. With no eligible request, no grant is issued and the pointer is unchanged.
- req in CLOSED or TALLIED: no grant, and the request is not queued.
- A cycle with close_cmd high in OPEN issues no grant. Close has priority, and a pending req is never granted afterward.

**Tally**
- On a grant to booth i, counter[vote_opt[i]] increments and total_votes increments, at the same edge that raises grant.
- Counter saturation: a counter at 2^COUNT_W−1 holds its value, overflow is set, and the grant is still issued.
- total_votes saturates at its maximum. In practice it cannot saturate before overflow is set.
- All four counters, total_votes, overflow and the pointer clear only on reset.

**Read port**
- In TALLIED, rd_count is loaded each cycle with counter[rd_sel].
- In other states, rd_count is 0.

**Reset values**
- grant = 0, voting_open = 0, results_valid = 0, total_votes = 0, overflow = 0, rd_count = 0.
- All counters = 0, state = CLOSED, pointer at booth 0.
- Reset mid-OPEN discards all counts and any in-flight request.

## Timing

- open_cmd sampled at edge N: voting_open is high from N+1. The first grant can appear at N+2 for a req already high at N+1.
- req high at edge N with the booth eligible and winning: grant[i] is high for exactly the cycle after N. The counter and total_votes reflect the vote in that same cycle.
- The booth must deassert req at the edge where it samples grant. A req still high one cycle after the grant is treated as a new vote.
- Back-to-back grants to different booths on consecutive cycles are supported, giving full throughput of 1 vote/cycle.
- close_cmd at edge N: voting_open falls and results_valid rises at N+1.
- rd_sel at edge N (in TALLIED): rd_count is valid at N+1, giving a 1-cycle read latency.
- reset has priority over every other input on the same edge.

## Test plan

1. **Reset and phase sequencing.** Apply reset, then open_cmd, then close_cmd.
   - Required: all outputs 0 after reset; voting_open=1 one cycle after open_cmd.
   - Required: results_valid=1 and voting_open=0 one cycle after close_cmd.
2. **Single vote.** In OPEN, booth 1 raises req with option 2 and drops it on grant.
   - Required: grant=4'b0010 for exactly one cycle; total_votes=1.
   - Required: after close, rd_sel=2 gives rd_count=1 and rd_sel=0 gives 0.
3. **Contention.** All 4 booths hold req simultaneously, each voting option 3, and each drops req on its own grant.
   - Required: grants in order booth 0, 1, 2, 3 on consecutive cycles.
   - Required: total_votes=4; counter[3]=4 after close.
4. **Round-robin fairness.** Booth 2 has just been granted, then booths 0 and 2 request together.
   - Required: booth 0 is granted first.
5. **Requests outside OPEN.** Raise req in CLOSED, then in TALLIED; also pulse close_cmd in the same cycle as a pending req.
   - Required: no grant in any case; total_votes unchanged.
6. **Saturation.** With COUNT_W=2, issue 5 votes for option 1.
   - Required: 5 grants; rd_count=3; overflow=1; total_votes=5.
   - Then apply reset: all counts clear and overflow=0.
